// File: rtl/ag_tcu_block_scaler.sv
// E8M0 block-scale and saturating K-tile accumulate. A closing beat accepted in cycle T gives out_valid in T+2.
// Only closing beats stall, and only while an unread result is held. AG_TCU_SCALER_ROUND_EN selects half-up right shifts.
module ag_tcu_block_scaler #(
    parameter int NUM_LANES  = 4,
    parameter int DATAW      = 24,
    parameter int ACCW       = 32,
    parameter int SCALEW     = 8,
    parameter int SCALE_BIAS = 127,
    parameter int MAX_STEPS  = 8,
    parameter int TAGW       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*DATAW-1:0] in_data,
    input  logic [SCALEW-1:0]          in_scale_a,
    input  logic [SCALEW-1:0]          in_scale_b,
    input  logic                       in_last,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES*ACCW-1:0]  out_data,
    output logic [TAGW-1:0]            out_tag,
    output logic [NUM_LANES-1:0]       out_sat,
    output logic                       out_nan,
    output logic                       out_forced
);

    localparam int SHW  = SCALEW + 2;
    localparam int CNTW = $clog2(MAX_STEPS);
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic signed [SHW-1:0]  SH_MAX  = SHW'(ACCW - 1);
    localparam logic signed [SHW-1:0]  SH_MIN  = -SH_MAX;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Returns {sat, value}: one lane scaled by 2^sh with ACCW saturation.
    function automatic logic [ACCW:0] scale_lane(
        input logic signed [DATAW-1:0] d,
        input logic signed [SHW-1:0]   sh
    );
        logic signed [ACCW-1:0]   ext;
        logic signed [ACCW-1:0]   val;
        logic signed [2*ACCW-1:0] wide;
        logic [SHW-1:0]           amt;
        logic                     sat;
`ifdef AG_TCU_SCALER_ROUND_EN
        logic signed [ACCW:0]     rsum;
        logic signed [ACCW-1:0]   rsat;
`endif
        ext  = ACCW'(d);
        sat  = 1'b0;
        wide = '0;
        if (!sh[SHW-1]) begin
            amt  = sh;
            wide = (2*ACCW)'(ext) <<< amt;
            if (wide > (2*ACCW)'(ACC_MAX)) begin
                val = ACC_MAX;
                sat = 1'b1;
            end else if (wide < (2*ACCW)'(ACC_MIN)) begin
                val = ACC_MIN;
                sat = 1'b1;
            end else begin
                val = ACCW'(wide);
            end
        end else begin
            amt = -sh;
`ifdef AG_TCU_SCALER_ROUND_EN
            rsum = (ACCW+1)'(ext) + ((ACCW+1)'(1) << (amt - SHW'(1)));
            if (rsum > (ACCW+1)'(ACC_MAX)) begin
                rsat = ACC_MAX;
                sat  = 1'b1;
            end else begin
                rsat = ACCW'(rsum);
            end
            val = rsat >>> amt;
`else
            val = ext >>> amt;
`endif
        end
        return {sat, val};
    endfunction

    logic signed [SHW-1:0]  raw_shift;
    logic signed [SHW-1:0]  shift;
    logic                   in_nan;
    logic [ACCW:0]          lane_res;
    logic signed [ACCW-1:0] in_lane [NUM_LANES];
    logic [NUM_LANES-1:0]   in_sat;

    logic                   s1_valid;
    logic signed [ACCW-1:0] s1_lane [NUM_LANES];
    logic [NUM_LANES-1:0]   s1_sat;
    logic                   s1_nan;
    logic                   s1_last;
    logic [TAGW-1:0]        s1_tag;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNTW-1:0]        step_cnt;
    logic                   at_limit;
    logic                   beat_closing;
    logic                   beat_forced;
    logic                   s1_advance;

    logic signed [ACCW-1:0] acc [NUM_LANES];
    logic [NUM_LANES-1:0]   acc_sat;
    logic                   acc_nan;
    logic signed [ACCW:0]   add_wide;
    logic signed [ACCW-1:0] acc_nxt [NUM_LANES];
    logic [NUM_LANES-1:0]   add_sat;
    logic [NUM_LANES-1:0]   sat_nxt;

    // Stage 1: combined exponent, clamped so every shift stays inside the accumulator width.
    always_comb begin
        raw_shift = $signed({2'b00, in_scale_a}) + $signed({2'b00, in_scale_b})
                  - SHW'(2 * SCALE_BIAS);
        if (raw_shift > SH_MAX) begin
            shift = SH_MAX;
        end else if (raw_shift < SH_MIN) begin
            shift = SH_MIN;
        end else begin
            shift = raw_shift;
        end
        in_nan   = (in_scale_a == '1) || (in_scale_b == '1);
        lane_res = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_res   = scale_lane(in_data[i*DATAW +: DATAW], shift);
            in_lane[i] = in_nan ? '0 : lane_res[ACCW-1:0];
            in_sat[i]  = !in_nan && lane_res[ACCW];
        end
    end

    assign in_ready = !s1_valid || s1_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sat   <= '0;
            s1_nan   <= 1'b0;
            s1_last  <= 1'b0;
            s1_tag   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                s1_lane[i] <= '0;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lane <= in_lane;
                s1_sat  <= in_sat;
                s1_nan  <= in_nan;
                s1_last <= in_last;
                s1_tag  <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s1_advance && !beat_closing) state_nxt = ACCUM;
            ACCUM:   if (s1_advance && beat_closing)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A closing beat may only leave S1 when the result register can take it.
    always_comb begin
        at_limit     = (state == ACCUM) && (step_cnt == CNTW'(MAX_STEPS - 1));
        beat_closing = s1_last || at_limit;
        beat_forced  = at_limit && !s1_last;
        s1_advance   = s1_valid && (!beat_closing || !out_valid || out_ready);
    end

    always_comb begin
        add_wide = '0;
        add_sat  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            add_wide = (ACCW+1)'(acc[i]) + (ACCW+1)'(s1_lane[i]);
            if (add_wide > (ACCW+1)'(ACC_MAX)) begin
                acc_nxt[i] = ACC_MAX;
                add_sat[i] = 1'b1;
            end else if (add_wide < (ACCW+1)'(ACC_MIN)) begin
                acc_nxt[i] = ACC_MIN;
                add_sat[i] = 1'b1;
            end else begin
                acc_nxt[i] = ACCW'(add_wide);
            end
        end
        sat_nxt = acc_sat | s1_sat | add_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sat  <= '0;
            acc_nan  <= 1'b0;
            step_cnt <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc[i] <= '0;
            end
        end else if (s1_advance) begin
            if (beat_closing) begin
                acc_sat  <= '0;
                acc_nan  <= 1'b0;
                step_cnt <= '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    acc[i] <= '0;
                end
            end else begin
                acc      <= acc_nxt;
                acc_sat  <= sat_nxt;
                acc_nan  <= acc_nan | s1_nan;
                step_cnt <= step_cnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_sat    <= '0;
            out_nan    <= 1'b0;
            out_forced <= 1'b0;
        end else if (s1_advance && beat_closing) begin
            out_valid  <= 1'b1;
            out_tag    <= s1_tag;
            out_sat    <= sat_nxt;
            out_nan    <= acc_nan | s1_nan;
            out_forced <= beat_forced;
            for (int i = 0; i < NUM_LANES; i++) begin
                out_data[i*ACCW +: ACCW] <= acc_nxt[i];
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ag_tcu_block_scaler.sv
// Directed and random bench for ag_tcu_block_scaler against an integer-arithmetic tile model.
module tb_ag_tcu_block_scaler;
    localparam int NL = 4;
    localparam int DW = 24;
    localparam int AW = 32;
    localparam int MS = 8;
    localparam longint AMAX = (64'sd1 <<< 31) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< 31);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [NL*DW-1:0] in_data;
    logic [7:0]       in_scale_a;
    logic [7:0]       in_scale_b;
    logic             in_last;
    logic [3:0]       in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [NL*AW-1:0] out_data;
    logic [3:0]       out_tag;
    logic [NL-1:0]    out_sat;
    logic             out_nan;
    logic             out_forced;

    ag_tcu_block_scaler #(
        .NUM_LANES(NL), .DATAW(DW), .ACCW(AW), .SCALEW(8),
        .SCALE_BIAS(127), .MAX_STEPS(MS), .TAGW(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_scale_a(in_scale_a), .in_scale_b(in_scale_b),
        .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_sat(out_sat), .out_nan(out_nan), .out_forced(out_forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*AW-1:0] data;
        logic [3:0]       tag;
        logic [NL-1:0]    sat;
        logic             nan;
        logic             forced;
    } exp_t;

    exp_t          exp_q[$];
    longint        m_acc[NL];
    logic [NL-1:0] m_sat;
    logic          m_nan;
    int            m_cnt;
    int            checks = 0;
    int            errors = 0;
    bit            rand_rdy = 0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) m_acc[i] = 0;
        m_sat = '0;
        m_nan = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic longint floor_div(input longint v, input longint p);
        longint q;
        q = v / p;
        if ((v % p != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    // Value of one beat lane is lane * 2^(a+b-254), saturated to 32 bits; tiles close on last or the 8th beat.
    function automatic void model_beat(input logic [NL*DW-1:0] d, input int a, input int b,
                                       input logic last, input logic [3:0] tag);
        int     sh;
        longint v;
        longint p;
        logic   nan;
        exp_t   e;
        sh = a + b - 254;
        if (sh > 31) sh = 31;
        if (sh < -31) sh = -31;
        nan = (a == 255) || (b == 255);
        for (int i = 0; i < NL; i++) begin
            v = longint'($signed(d[i*DW +: DW]));
            if (nan) begin
                v = 0;
            end else if (sh >= 0) begin
                v = v * (longint'(1) << sh);
                if (v > AMAX) begin v = AMAX; m_sat[i] = 1'b1; end
                else if (v < AMIN) begin v = AMIN; m_sat[i] = 1'b1; end
            end else begin
                p = longint'(1) << (-sh);
`ifdef AG_TCU_SCALER_ROUND_EN
                v = v + p / 2;
                if (v > AMAX) begin v = AMAX; m_sat[i] = 1'b1; end
`endif
                v = floor_div(v, p);
            end
            m_acc[i] = m_acc[i] + v;
            if (m_acc[i] > AMAX) begin m_acc[i] = AMAX; m_sat[i] = 1'b1; end
            else if (m_acc[i] < AMIN) begin m_acc[i] = AMIN; m_sat[i] = 1'b1; end
        end
        m_nan = m_nan | nan;
        m_cnt++;
        if (last || m_cnt == MS) begin
            e.data = '0;
            for (int i = 0; i < NL; i++) e.data[i*AW +: AW] = AW'(m_acc[i]);
            e.tag    = tag;
            e.sat    = m_sat;
            e.nan    = m_nan;
            e.forced = !last;
            exp_q.push_back(e);
            model_clear();
        end
    endfunction

    function automatic logic [NL*DW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [NL*DW-1:0] r;
        r[0*DW +: DW] = DW'(v0);
        r[1*DW +: DW] = DW'(v1);
        r[2*DW +: DW] = DW'(v2);
        r[3*DW +: DW] = DW'(v3);
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_beat(input logic [NL*DW-1:0] d, input int a, input int b,
                             input logic last, input logic [3:0] tag);
        int n;
        in_valid   = 1'b1;
        in_data    = d;
        in_scale_a = 8'(a);
        in_scale_b = 8'(b);
        in_last    = last;
        in_tag     = tag;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            model_beat(d, a, b, last, tag);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_idle", out_valid, 0);
    endtask

    initial begin : monitor
        logic             hold;
        logic [159:0]     snap;
        logic [159:0]     cur;
        exp_t             e;
        hold = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            #4;
            cur = 160'({out_data, out_tag, out_sat, out_nan, out_forced});
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_stable", cur, snap);
                end
                if (out_valid && out_ready) begin
                    check("out_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_tag", out_tag, e.tag);
                        check("out_sat", out_sat, e.sat);
                        check("out_nan", out_nan, e.nan);
                        check("out_forced", out_forced, e.forced);
                    end
                end
                hold = out_valid && !out_ready;
                snap = cur;
            end
        end
    end

    initial begin : stim
        int len;
        int sa;
        logic [NL*DW-1:0] d;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_scale_a = 8'd127;
        in_scale_b = 8'd127;
        in_last    = 1'b0;
        in_tag     = '0;
        out_ready  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_flags", {out_sat, out_nan, out_forced}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // single-beat tile and its two-cycle latency
        send_beat(pack4(1, 2, -3, 4), 127, 127, 1'b1, 4'h1);
        check("lat_t1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", out_valid, 1);
        check("lat_t2_data", out_data, {32'd4, -32'sd3, 32'd2, 32'd1});
        drain();

        // three-beat tile: 16 + 4 + 8
        send_beat(pack4(8, 8, 8, 8), 128, 127, 1'b0, 4'h7);
        send_beat(pack4(8, 8, 8, 8), 127, 126, 1'b0, 4'h8);
        send_beat(pack4(8, 8, 8, 8), 127, 127, 1'b1, 4'h9);
        drain();

        // left-shift saturation, then a clean tile
        send_beat(pack4(24'h7FFFFF, 1, -1, 0), 135, 135, 1'b1, 4'h2);
        send_beat(pack4(5, 6, 7, 8), 127, 127, 1'b1, 4'h3);
        drain();

        // NaN on beat 2 of a tile forced closed at MAX_STEPS
        for (int b = 0; b < MS; b++) begin
            send_beat(pack4(10, 20, -30, 40), (b == 1) ? 255 : 127, 127, 1'b0, 4'(b));
        end
        drain();

        // back-pressure with two closing beats queued
        out_ready = 1'b0;
        send_beat(pack4(100, 200, 300, 400), 127, 127, 1'b1, 4'hA);
        send_beat(pack4(-1, -2, -3, -4), 127, 127, 1'b1, 4'hB);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        repeat (5) @(negedge clk);
        check("bp_held_tag", out_tag, 4'hA);
        drain();

        // right shift of 3 by one
        send_beat(pack4(3, -3, 5, 1), 127, 126, 1'b1, 4'hC);
        drain();

        // reset in the middle of a tile drops the partial sum
        send_beat(pack4(1000, 1000, 1000, 1000), 127, 127, 1'b0, 4'h4);
        send_beat(pack4(1000, 1000, 1000, 1000), 127, 127, 1'b0, 4'h5);
        reset = 1'b1;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        send_beat(pack4(7, -7, 9, -9), 127, 127, 1'b1, 4'hD);
        drain();

        // random tiles with random result back-pressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(1, 11);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < NL; i++) begin
                    if ($urandom_range(0, 1) == 0) d[i*DW +: DW] = DW'($urandom);
                    else d[i*DW +: DW] = DW'(int'($urandom_range(0, 2000)) - 1000);
                end
                sa = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(112, 140));
                send_beat(d, sa, int'($urandom_range(115, 139)), (b == len - 1), 4'($urandom));
                if ($urandom_range(0, 7) == 0) @(negedge clk);
            end
        end
        rand_rdy = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ag_tcu_block_scaler.md
Name: ag_tcu_block_scaler

Overview:
- Parametrised successor of the AG tensor-core scale stage.
- Takes NUM_LANES signed partial products per beat, each beat tagged with a pair of E8M0 block scales.
- Applies the combined power-of-two scale per beat and accumulates beats over a K-tile with saturation.
- Emits one accumulated vector per tile. Sits between the TCU dot-product array and the commit/result path; full throughput via valid/ready on both sides.

Parameters:
- NUM_LANES, 4: lanes per beat.
- DATAW, 24: signed lane product width.
- ACCW, 32: signed accumulator/output lane width (ACCW >= DATAW).
- SCALEW, 8: width of each E8M0 scale.
- SCALE_BIAS, 127: E8M0 exponent bias.
- MAX_STEPS, 8: max beats per tile (>= 2).
- TAGW, 4: tile tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  NUM_LANES*DATAW  signed lane products; lane i = bits [i*DATAW +: DATAW]
- in_scale_a  in  SCALEW  E8M0 scale of the A block
- in_scale_b  in  SCALEW  E8M0 scale of the B block
- in_last  in  1  final beat of tile
- in_tag  in  TAGW  tile tag
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  NUM_LANES*ACCW  accumulated lanes
- out_tag  out  TAGW  tag of the tile's closing beat
- out_sat  out  NUM_LANES  per-lane sticky saturation flag for the tile
- out_nan  out  1  some beat in the tile carried a NaN scale
- out_forced  out  1  tile closed by MAX_STEPS rather than in_last

Behaviour:
- Reset: all valids 0, accumulators 0, step count 0, sticky flags 0, out_data/out_tag/out_sat/out_nan/out_forced 0.
- Stage S1 (registered on accept):
  - shift = in_scale_a + in_scale_b - 2*SCALE_BIAS, signed SCALEW+2 bits, clamped to [-(ACCW-1), ACCW-1].
  - Each lane is sign-extended to ACCW.
  - shift >= 0: left shift; saturate to ACCW signed max/min on overflow and set that lane's sat bit.
  - shift < 0: arithmetic right shift, truncating toward -inf.
  - NaN: either scale == all-ones means the beat's lanes contribute 0 and the NaN bit is set.
- Stage S2 (accumulate):
  - acc[i] += s1 lane[i], saturating add; saturation sets the sticky sat bit.
  - Non-closing beats are always absorbed.
  - A closing beat (last or forced) writes acc+lane into the output register along with the tag and flags. In the same cycle, acc, the flags and the step count clear to 0.
- Closing beat absorb rule: only if the output register is empty or out_ready is high that cycle. Otherwise S1 holds.
- in_ready = !s1_valid || s1_advance, combinational from out_ready. Zero bubbles between back-to-back tiles.
- Latency: closing beat accepted in cycle T gives out_valid in T+2. Single-beat tiles are allowed (in_last on the first beat).
- Output register: holds stable while out_valid && !out_ready; clears valid on handshake with no new closing beat.
- Step counter:
  - Increments per S1 beat absorbed.
  - The beat that makes the count reach MAX_STEPS without in_last is forced closing; out_forced = 1.
  - The next beat starts a new tile.
- FSM: IDLE (count 0) -> ACCUM on first non-closing beat -> IDLE on closing beat. Output register state is independent of this FSM.
- Reset mid-tile discards the partial accumulator and any pending output.

Optional Feature:
- AG_TCU_SCALER_ROUND_EN defined: right shifts round half-up, i.e. add 2^(-shift-1) before shifting, with saturation applied after the add.
- Undefined: truncation toward -inf.
- Left shifts and the NaN path are identical in both builds.

Test Plan:
- Single-beat tile: lanes {1,2,-3,4}, scales a=127, b=127, in_last=1, out_ready=1 -> out_valid 2 cycles later with {1,2,-3,4}, all flags 0.
- 3-beat tile: lanes all 8, scales (128,127), (127,126), (127,127) -> per-lane 16+4+8=28; tag of beat 3 output; no interim out_valid.
- Saturation: DATAW=24 lane 0x7FFFFF, a=b=135 (shift 16) -> lane = 0x7FFFFFFF, out_sat[0]=1. Next tile clean -> out_sat=0.
- NaN/forced: a=0xFF on beat 2 of 8 non-last beats, MAX_STEPS=8 -> out_nan=1 and out_forced=1 after beat 8; beat 2 contributes 0.
- Back-pressure: out_ready=0 for 5 cycles with two closing beats queued -> first result held stable, in_ready drops, no loss. Both results emitted in order once out_ready=1.
- Rounding: lane 3, shift -1 -> 1 without AG_TCU_SCALER_ROUND_EN, 2 with it. Reset asserted mid-tile -> next tile result excludes earlier beats.
